// File: rtl/alarm_bank.sv
// alarm_bank: N independent countdown alarms sharing one write port, with
// one-shot/periodic modes, sticky bells, overrun flags and a summary irq.
module alarm_bank #(
    parameter int W = 8,
    parameter int N = 4,
    parameter int S = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         tick,
    input  logic [S-1:0] sel,
    input  logic [W-1:0] value,
    input  logic         periodic,
    input  logic         put,
    input  logic         stop,
    input  logic [N-1:0] ack,
    output logic [N-1:0] bell,
    output logic [N-1:0] overrun,
    output logic [N-1:0] active,
    output logic         irq
);
    logic [W-1:0] cnt [N];
    logic [W-1:0] rld [N];
    logic [N-1:0] mode;
    logic [N-1:0] expire;

    always_comb begin
        expire = '0;
        for (int i = 0; i < N; i++)
            expire[i] = active[i] && tick && cnt[i] == W'(1);
    end

    // A channel index that no select value can reach simply never matches.
    always_ff @(posedge clock) begin
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                cnt[i] <= '0;
                rld[i] <= '0;
                mode[i] <= 1'b0;
                active[i] <= 1'b0;
                bell[i] <= 1'b0;
                overrun[i] <= 1'b0;
            end else if (sel == S'(i) && put && value != '0) begin
                cnt[i] <= value;
                rld[i] <= value;
                mode[i] <= periodic;
                active[i] <= 1'b1;
                bell[i] <= 1'b0;
                overrun[i] <= 1'b0;
            end else if (sel == S'(i) && (put || stop)) begin
                cnt[i] <= '0;
                active[i] <= 1'b0;
                bell[i] <= bell[i] & ~ack[i];
                overrun[i] <= overrun[i] & ~ack[i];
            end else begin
                bell[i] <= expire[i] | (bell[i] & ~ack[i]);
                overrun[i] <= (expire[i] & mode[i] & bell[i]) | (overrun[i] & ~ack[i]);
                if (expire[i]) begin
                    cnt[i] <= mode[i] ? rld[i] : '0;
                    active[i] <= mode[i];
                end else if (active[i] && tick) begin
                    cnt[i] <= cnt[i] - W'(1);
                end
            end
        end
    end

    assign irq = |bell;
endmodule

// File: doc/alarm_bank.md
# alarm_bank

Multi-channel programmable alarm timer: N independent countdown channels sharing one write port, each arming in one-shot or periodic mode and raising a sticky `bell` when its count expires. Counting advances only on a shared `tick` enable, so a prescaler or timebase strobe sets the time unit. `irq` summarises pending bells for an interrupt controller, and per-channel `overrun` flags report periodic expiries that software has not acknowledged.

## Interface
- `W`, 8, counter and reload width in bits
- `N`, 4, number of channels
- `S`, 2, channel-select width; requires 2^S >= N

- `clock`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; clears all state
- `tick`  in  1  count enable; armed channels decrement only in cycles with `tick`=1
- `sel`  in  S  channel addressed by `put`/`stop`
- `value`  in  W  load value for `put`
- `periodic`  in  1  mode captured by `put`: 1 = auto-reload, 0 = one-shot
- `put`  in  1  arm channel `sel` with `value`
- `stop`  in  1  disarm channel `sel`
- `ack`  in  N  per-channel bell/overrun clear, one bit per channel
- `bell`  out  N  sticky expiry flag per channel
- `overrun`  out  N  sticky: periodic expiry while that channel's `bell` was already 1
- `active`  out  N  channel armed and counting
- `irq`  out  1  OR of all `bell` bits (combinational from registers)

## Operation
- Per-channel state:
  - `cnt[W]`: current count
  - `rld[W]`: reload value
  - `mode`: 1 = periodic
  - `armed`: drives `active`
  - `bell`, `overrun`: sticky flags
- Reset: every `cnt`, `rld`, `mode`, `armed`, `bell` and `overrun` is 0, so `irq`=0.
- `put`, `value`>0 (channel `sel`):
  - `cnt`<=`value`, `rld`<=`value`, `mode`<=`periodic`, `armed`<=1
  - `bell`<=0, `overrun`<=0
- `put`, `value`=0: acts as `stop`.
- `stop` (channel `sel`): `armed`<=0, `cnt`<=0; `bell` and `overrun` are unchanged so a pending event still needs `ack`.
- Count, for each armed channel with `tick`=1 and no `put`/`stop` addressed to it:
  - If `cnt`>1: `cnt`<=`cnt`-1.
  - If `cnt`==1 (expiry): `bell`<=1.
    - Periodic: `cnt`<=`rld`, and `overrun`<=1 if `bell` was already 1.
    - One-shot: `armed`<=0, `cnt`<=0.
- `ack[i]`: clears `bell[i]` and `overrun[i]`.
- Arithmetic: unsigned, width W. `cnt` never wraps below 1 while armed, and a disarmed channel never decrements.

## Timing
- Priority within one channel, highest first:
  1. reset
  2. `put`
  3. `stop`
  4. expiry
  5. `ack`
- Expiry coinciding with `ack[i]`:
  - `bell[i]` stays 1 so the event is not lost.
  - `overrun[i]` is evaluated against the pre-edge `bell`, then the `ack` clear of `overrun` is overridden only if the new overrun sets it.
- `put` and `stop` together: `put` wins. `sel` >= N: `put` and `stop` are ignored.
- Latency: `put` sampled at edge k with `value`=v and `tick` held 1 gives `cnt`=v after edge k, `bell`=1 after edge k+v. The put cycle itself does not count.
- Periodic with `tick` held 1: expiries every v edges, with `bell` re-asserted, not pulsed.
- `active` is 1 after the edge that samples `put`. For one-shot it is 0 after the expiry edge.
- `tick`=0 freezes all counters; `put`, `stop` and `ack` still take effect.
- Reset mid-count: all outputs are 0 after the reset edge, and no expiry is reported for that edge.

## Test plan
- Reset, then `put` ch0 v=5 one-shot, `tick`=1:
  - `bell[0]` rises after edge k+5; `active[0]` falls on the same edge.
  - `irq`=1 until `ack[0]`, then 0.
- `put` ch2 v=3 periodic, `tick`=1, no `ack`:
  - `bell[2]` set after k+3.
  - `overrun[2]` set after k+6.
  - `ack[2]` clears both.
  - Next expiry after k+9 sets only `bell[2]`.
- `tick` toggling 1,0,1,0 with ch1 v=4: `bell[1]` after the 4th tick-high edge, not the 4th clock edge.
- Channel 3 at `cnt`=1 with `tick`=1 and `ack[3]` in the same cycle: `bell[3]`=1 afterwards.
- Channel 1 at `cnt`=1 with `tick`=1 and `put` ch1 v=7 in the same cycle: `bell[1]`=0, `cnt`=7.
- Stop and reset during a count:
  - `stop` ch0 mid-count: `active[0]`=0, no bell.
  - Assert `reset` while ch0–ch3 are armed with bells pending: all outputs 0 next cycle.
  - `sel`=N (when 2^S > N) with `put`: no state change.
